// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronizes the raw pins, deframes 11-bit frames and
// tracks make/break/extended prefixes to hold the code of the currently pressed key.
module ps2_scan_receiver #(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] keyboard_data,
    output logic       key_pressed,
    output logic       frame_valid,
    output logic [7:0] frame_data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   dat_s;
    logic [10:0]            shreg;
    logic [3:0]             bit_cnt;
    logic [TW-1:0]          timer;
    logic                   break_pending, ext_pending;
    logic                   shift_en, valid_set, err_set;
    logic                   frame_good;

    assign fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];

    // After 11 LSB-first shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
    assign frame_good = ~shreg[0] & shreg[10] & (^shreg[9:1]);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        state_next = state;
        shift_en   = 1'b0;
        valid_set  = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    shift_en   = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'd10) state_next = CHECK;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_set    = 1'b1;
                    state_next = IDLE;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (frame_good) valid_set = 1'b1;
                else            err_set   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_sync      <= {SYNC_STAGES{1'b1}};
            dat_sync      <= {SYNC_STAGES{1'b1}};
            clk_prev      <= 1'b1;
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            timer         <= '0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
            keyboard_data <= 8'h00;
            key_pressed   <= 1'b0;
            frame_valid   <= 1'b0;
            frame_data    <= 8'h00;
            frame_err     <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync    <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            clk_prev    <= clk_sync[SYNC_STAGES-1];
            state       <= state_next;
            frame_valid <= valid_set;
            frame_err   <= err_set;

            if (valid_set) frame_data <= shreg[8:1];

            if (shift_en) begin
                shreg   <= {dat_s, shreg[10:1]};
                bit_cnt <= (state == IDLE) ? 4'd1 : bit_cnt + 4'd1;
            end

            if (state == SHIFT && !fall) timer <= timer + 1'b1;
            else                         timer <= '0;

            // Prefix tracking runs on the byte presented with frame_valid.
            if (frame_valid) begin
                case (frame_data)
                    8'hE0: ext_pending <= 1'b1;
                    8'hF0: begin
                        break_pending <= 1'b1;
                        ext_pending   <= ext_pending;
                    end
                    default: begin
                        if (!break_pending) begin
                            keyboard_data <= frame_data;
                            key_pressed   <= 1'b1;
                        end else if (frame_data == keyboard_data) begin
                            keyboard_data <= 8'h00;
                            key_pressed   <= 1'b0;
                        end
                        break_pending <= 1'b0;
                        ext_pending   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: drives PS/2 frames on the pins, scores
// frame bytes through a queue and compares the held key against a small decode model.
module tb_ps2_scan_receiver;

    localparam int TIMEOUT   = 5000;
    localparam int SYNC      = 2;
    localparam int LAT       = SYNC + 2;
    localparam int SLOW_HALF = 1000;
    localparam int FAST_HALF = 40;

    logic       clock   = 1'b0;
    logic       resetn  = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] keyboard_data;
    logic       key_pressed;
    logic       frame_valid;
    logic [7:0] frame_data;
    logic       frame_err;

    int n_cmp     = 0;
    int n_bad     = 0;
    int err_count = 0;
    int exp_err   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_kbd = 8'h00;
    logic       m_kp  = 1'b0;
    logic       m_brk = 1'b0;

    always #10 clock = ~clock;

    ps2_scan_receiver #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .keyboard_data(keyboard_data),
        .key_pressed  (key_pressed),
        .frame_valid  (frame_valid),
        .frame_data   (frame_data),
        .frame_err    (frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every frame_valid and counts frame_err pulses.
    always @(negedge clock) begin
        if (frame_valid) begin
            check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("frame_data", 32'(frame_data), 32'(exp_q.pop_front()));
        end
        if (frame_valid || frame_err)
            check("valid_err_exclusive", 32'(frame_valid & frame_err), 32'd0);
        if (frame_err) err_count++;
    end

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b != 8'hE0) begin
            if (!m_brk) begin
                m_kbd = b;
                m_kp  = 1'b1;
            end else if (b == m_kbd) begin
                m_kbd = 8'h00;
                m_kp  = 1'b0;
            end
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int half, input int nbits, input bit measure);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        @(negedge clock);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = bits[i];
            repeat (half) @(negedge clock);
            ps2_clk = 1'b0;
            if (measure && i == 10) begin
                repeat (LAT - 1) @(negedge clock);
                check("latency_early", 32'(frame_valid), 32'd0);
                @(negedge clock);
                check("latency_on_time", 32'(frame_valid), 32'd1);
                check("latency_data", 32'(frame_data), 32'(b));
                repeat (half - LAT) @(negedge clock);
            end else begin
                repeat (half) @(negedge clock);
            end
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] b, input int half, input bit measure);
        exp_q.push_back(b);
        model_byte(b);
        send_bits(b, 1'b0, 1'b0, half, 11, measure);
        repeat (20) @(negedge clock);
    endtask

    task automatic send_bad(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        exp_err++;
        send_bits(b, bad_par, bad_stop, FAST_HALF, 11, 1'b0);
        repeat (20) @(negedge clock);
    endtask

    task automatic check_keys(input string tag);
        check({tag, "_kbd"}, 32'(keyboard_data), 32'(m_kbd));
        check({tag, "_kp"}, 32'(key_pressed), 32'(m_kp));
    endtask

    initial begin
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (1000) @(negedge clock);
        check_keys("reset");
        check("reset_frame_data", 32'(frame_data), 32'd0);
        check("reset_frame_valid", 32'(frame_valid), 32'd0);
        check("reset_errs", 32'(err_count), 32'd0);

        send_good(8'h1A, SLOW_HALF, 1'b1);
        check_keys("make_1a");

        send_good(8'hE0, FAST_HALF, 1'b0);
        send_good(8'h75, FAST_HALF, 1'b0);
        check_keys("ext_make_75");
        send_good(8'hE0, FAST_HALF, 1'b0);
        send_good(8'hF0, FAST_HALF, 1'b0);
        send_good(8'h75, FAST_HALF, 1'b0);
        check_keys("ext_break_75");

        send_good(8'h6B, FAST_HALF, 1'b0);
        send_good(8'h74, FAST_HALF, 1'b0);
        check_keys("make_74");
        send_good(8'hF0, FAST_HALF, 1'b0);
        send_good(8'h6B, FAST_HALF, 1'b0);
        check_keys("break_6b_other_held");
        send_good(8'hF0, FAST_HALF, 1'b0);
        send_good(8'h74, FAST_HALF, 1'b0);
        check_keys("break_74");

        send_good(8'h1A, FAST_HALF, 1'b0);
        send_bad(8'h72, 1'b1, 1'b0);
        check("parity_err_count", 32'(err_count), 32'(exp_err));
        check_keys("after_parity_err");
        send_bad(8'h72, 1'b0, 1'b1);
        check("stop_err_count", 32'(err_count), 32'(exp_err));
        check_keys("after_stop_err");

        exp_err++;
        send_bits(8'h55, 1'b0, 1'b0, FAST_HALF, 5, 1'b0);
        repeat (TIMEOUT + 100) @(negedge clock);
        check("timeout_err_count", 32'(err_count), 32'(exp_err));
        send_good(8'h75, FAST_HALF, 1'b0);
        check_keys("after_timeout");

        send_bits(8'h33, 1'b0, 1'b0, FAST_HALF, 5, 1'b0);
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        m_kbd = 8'h00;
        m_kp  = 1'b0;
        m_brk = 1'b0;
        repeat (50) @(negedge clock);
        check_keys("mid_reset");
        check("mid_reset_frame_data", 32'(frame_data), 32'd0);
        check("mid_reset_no_err", 32'(err_count), 32'(exp_err));
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
